// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator (average rate f_clk*NUM/DEN)
// with a settle/lock sequencer that restarts all channel phases on every ratio apply.
module clk_en_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 16,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM     = {16'd6, 16'd48},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN     = {16'd50, 16'd50}
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] ce_tgl,
    output logic              locked
);
    localparam int CW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LOCK_CYCLES - 1);

    typedef enum logic {SETTLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state  <= SETTLE;
            cnt    <= CNT_INIT;
            locked <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            locked <= state == LOCKED && !cfg_apply;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (cfg_apply) begin
            state_nx = SETTLE;
            cnt_nx   = CNT_INIT;
        end else if (state == SETTLE) begin
            if (cnt == '0) state_nx = LOCKED;
            else cnt_nx = cnt - 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [2:0] IDX = 3'(i);
        logic [ACC_W-1:0] sh_num, sh_den, act_num, act_den, acc, n_eff, nxt;
        logic [ACC_W:0]   sum;
        logic             wr, en, hit, ce_q, tgl_q;
        assign wr    = cfg_we && cfg_ch == IDX;
        assign en    = act_num != '0 && act_den != '0;
        // NUM above DEN saturates to one strobe per cycle
        assign n_eff = act_num > act_den ? act_den : act_num;
        assign sum   = {1'b0, acc} + {1'b0, n_eff};
        assign hit   = sum >= {1'b0, act_den};
        assign nxt   = ACC_W'(hit ? sum - {1'b0, act_den} : sum);

        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                sh_num  <= DEF_NUM[i*ACC_W +: ACC_W];
                sh_den  <= DEF_DEN[i*ACC_W +: ACC_W];
                act_num <= DEF_NUM[i*ACC_W +: ACC_W];
                act_den <= DEF_DEN[i*ACC_W +: ACC_W];
                acc     <= '0;
                ce_q    <= 1'b0;
                tgl_q   <= 1'b0;
            end else begin
                if (wr) begin
                    sh_num <= cfg_num;
                    sh_den <= cfg_den;
                end
                if (cfg_apply) begin
                    act_num <= wr ? cfg_num : sh_num;
                    act_den <= wr ? cfg_den : sh_den;
                end
                if (!cfg_apply && state == LOCKED && en) begin
                    acc   <= nxt;
                    ce_q  <= hit;
                    tgl_q <= tgl_q ^ hit;
                end else begin
                    acc  <= '0;
                    ce_q <= 1'b0;
                end
            end
        end

        assign ce[i]     = ce_q;
        assign ce_tgl[i] = tgl_q;
    end
endmodule
